// File: rtl/text_banner_pkg.sv
// rtl/text_banner_pkg.sv - shared types and constants for the end-of-game banner overlay
package text_banner_pkg;

  typedef enum logic [1:0] {IDLE, REVEAL, SHOWN} banner_state_t;
  typedef enum logic {OUT_LOSE, OUT_WIN} outcome_t;

  localparam int LOSE_LEN = 5;
  localparam int WIN_LEN  = 7;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;

endpackage

// File: rtl/banner_msg_rom.sv
// rtl/banner_msg_rom.sv - ASCII code lookup for the banner messages
module banner_msg_rom
  import text_banner_pkg::*;
(
  input  outcome_t   outcome,
  input  logic [2:0] ci,
  output logic [7:0] code
);

  // Character table; positions past the message length read as blank (0x00)
  always_comb begin
    code = 8'h00;
    if (outcome == OUT_LOSE) begin
      case (ci)
        3'd0: code = 8'h4C;
        3'd1: code = 8'h75;
        3'd2: code = 8'h73;
        3'd3: code = 8'h65;
        3'd4: code = 8'h72;
        default: code = 8'h00;
      endcase
    end else begin
      case (ci)
        3'd0: code = 8'h57;
        3'd1: code = 8'h49;
        3'd2: code = 8'h4E;
        3'd3: code = 8'h52;
        3'd4: code = 8'h41;
        3'd5: code = 8'h52;
        3'd6: code = 8'h21;
        default: code = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/text_banner_ctrl.sv
// rtl/text_banner_ctrl.sv - reveal/blink sequencer and two-stage font pixel pipeline for the banner
module text_banner_ctrl
  import text_banner_pkg::*;
#(
  parameter logic [9:0] BANNER_X     = 10'd288,
  parameter logic [9:0] BANNER_Y     = 10'd232,
  parameter int         CHAR_FRAMES  = 4,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        didWin,
  input  logic        didLose,
  input  logic        clear,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        banner_pix_on,
  output logic        banner_active,
  output logic        banner_done
);

  localparam logic [5:0] CHAR_CNT  = 6'(CHAR_FRAMES);
  localparam logic [5:0] BLINK_CNT = 6'(BLINK_FRAMES);

  banner_state_t state, nextState;
  outcome_t      outcome, nextOutcome;
  logic [2:0]    revealed, nextRevealed;
  logic [5:0]    frameCnt, nextFrameCnt;
  logic          blinkVis, nextBlinkVis;

  logic [2:0]    msgLen;
  logic [9:0]    relX, relY;
  logic          inBox, charLit, vis1;
  logic [7:0]    romCode, code;
  logic [2:0]    colQ;
  logic          vis1Q;

  assign msgLen = (outcome == OUT_WIN) ? 3'(WIN_LEN) : 3'(LOSE_LEN);

  // Sequencer state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      outcome  <= OUT_LOSE;
      revealed <= 3'd0;
      frameCnt <= 6'd0;
      blinkVis <= 1'b1;
    end else begin
      state    <= nextState;
      outcome  <= nextOutcome;
      revealed <= nextRevealed;
      frameCnt <= nextFrameCnt;
      blinkVis <= nextBlinkVis;
    end
  end

  // Next-state: clear dominates everything; the outcome is only sampled from IDLE
  always_comb begin
    nextState    = state;
    nextOutcome  = outcome;
    nextRevealed = revealed;
    nextFrameCnt = frameCnt;
    nextBlinkVis = blinkVis;
    if (clear) begin
      nextState    = IDLE;
      nextOutcome  = OUT_LOSE;
      nextRevealed = 3'd0;
      nextFrameCnt = 6'd0;
      nextBlinkVis = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (didLose | didWin) begin
            nextState    = REVEAL;
            nextOutcome  = didLose ? OUT_LOSE : OUT_WIN;
            nextRevealed = 3'd1;
            nextFrameCnt = 6'd0;
            nextBlinkVis = 1'b1;
          end
        end
        REVEAL: begin
          if (frame_start) begin
            if (frameCnt + 6'd1 == CHAR_CNT) begin
              nextFrameCnt = 6'd0;
              nextRevealed = revealed + 3'd1;
              if (revealed + 3'd1 == msgLen) nextState = SHOWN;
            end else begin
              nextFrameCnt = frameCnt + 6'd1;
            end
          end
        end
        SHOWN: begin
          if (frame_start) begin
            if (frameCnt + 6'd1 == BLINK_CNT) begin
              nextFrameCnt = 6'd0;
              nextBlinkVis = ~blinkVis;
            end else begin
              nextFrameCnt = frameCnt + 6'd1;
            end
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Stage 1 geometry: underflow of relX/relY wraps large and falls outside the box
  assign relX = DrawX - BANNER_X;
  assign relY = DrawY - BANNER_Y;
  assign inBox = (relX < 10'(GLYPH_W) * {7'd0, msgLen}) && (relY < 10'(GLYPH_H));

  banner_msg_rom uMsgRom (
    .outcome (outcome),
    .ci      (relX[5:3]),
    .code    (romCode)
  );

  assign charLit = inBox && (state != IDLE) && (relX[9:3] < {4'd0, revealed})
                   && (romCode != 8'h00);
  assign code    = charLit ? romCode : 8'h00;
  assign vis1    = charLit && ((state != SHOWN) || blinkVis);

  // Stage 1 register: glyph row address plus the column/visibility that travel with it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      font_addr <= 11'd0;
      colQ      <= 3'd0;
      vis1Q     <= 1'b0;
    end else begin
      font_addr <= {code[6:0], relY[3:0]};
      colQ      <= relX[2:0];
      vis1Q     <= vis1;
    end
  end

  // Stage 2 register: pick the glyph bit (bit 7 is leftmost) and decode state flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      banner_pix_on <= 1'b0;
      banner_active <= 1'b0;
      banner_done   <= 1'b0;
    end else begin
      banner_pix_on <= vis1Q & font_data[3'd7 - colQ];
      banner_active <= (state != IDLE);
      banner_done   <= (state == SHOWN);
    end
  end

endmodule

// File: tb/tb_text_banner_ctrl.sv
// tb/tb_text_banner_ctrl.sv - self-checking bench for text_banner_ctrl
module tb_text_banner_ctrl;

  localparam logic [9:0] BX = 10'd288;
  localparam logic [9:0] BY = 10'd232;
  localparam int CF = 4;
  localparam int BF = 30;

  logic        Clk, Reset_n, didWin, didLose, clear, frame_start;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        banner_pix_on, banner_active, banner_done;

  int errors = 0;
  int checks = 0;

  text_banner_ctrl #(
    .BANNER_X(BX), .BANNER_Y(BY), .CHAR_FRAMES(CF), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .didWin(didWin), .didLose(didLose),
    .clear(clear), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .font_addr(font_addr), .font_data(font_data), .banner_pix_on(banner_pix_on),
    .banner_active(banner_active), .banner_done(banner_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in glyph ROM: each row pattern is the upper address bits
  function automatic logic [7:0] fontFn(input logic [10:0] a);
    return a[10:3];
  endfunction

  always_comb font_data = fontFn(font_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: banner contents derived from frames elapsed since the outcome latched
  string loseMsg = "Luser";
  string winMsg  = "WINRAR!";
  bit          mActive, mWin;
  int          mFrames;
  logic [10:0] eAddr;
  logic        eBit, ePix, eActive, eDone;
  int          len, rev, shownAt, ci;
  bit          shown, blinkOn, vis;
  logic [9:0]  rx, ry;
  logic [7:0]  mCode, fb;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mActive = 0; mWin = 0; mFrames = 0;
      eAddr = '0; eBit = 0; ePix = 0; eActive = 0; eDone = 0;
    end else begin
      len     = mWin ? 7 : 5;
      rev     = 1 + mFrames / CF;
      if (rev > len) rev = len;
      shownAt = CF * (len - 1);
      shown   = mFrames >= shownAt;
      blinkOn = !shown || (((mFrames - shownAt) / BF) % 2 == 0);
      rx = DrawX - BX;
      ry = DrawY - BY;
      ci = int'(rx) / 8;
      mCode = 8'h00;
      if (mActive && int'(rx) < 8 * len && int'(ry) < 16 && ci < rev)
        mCode = mWin ? winMsg[ci] : loseMsg[ci];
      vis = (mCode != 8'h00) && blinkOn;
      ePix  = eBit;
      eAddr = {mCode[6:0], ry[3:0]};
      fb    = fontFn(eAddr);
      eBit  = vis && fb[7 - int'(rx[2:0])];
      eActive = mActive;
      eDone   = mActive && shown;
      if (clear) begin
        mActive = 0; mFrames = 0;
      end else if (!mActive) begin
        if (didWin || didLose) begin
          mActive = 1; mWin = !didLose; mFrames = 0;
        end
      end else if (frame_start) begin
        mFrames++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge Clk) begin
    chk("model font_addr", 32'(font_addr), 32'(eAddr));
    chk("model pix_on", 32'(banner_pix_on), 32'(ePix));
    chk("model active", 32'(banner_active), 32'(eActive));
    chk("model done", 32'(banner_done), 32'(eDone));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic framePulses(input int n);
    for (int i = 0; i < n; i++) begin
      DrawX = BX - 10'd2 + 10'((i * 13) % 64);
      DrawY = BY + 10'(i % 17);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic pixAt(input logic [9:0] x, input logic [9:0] y, input string name, input logic exp);
    DrawX = x;
    DrawY = y;
    cyc(3);
    chk(name, 32'(banner_pix_on), 32'(exp));
  endtask

  logic [7:0] wRow0;

  initial begin
    wRow0 = 8'hAE;
    Reset_n = 1'b0; didWin = 0; didLose = 0; clear = 0; frame_start = 0;
    DrawX = BX; DrawY = BY;
    cyc(3);
    chk("reset font_addr", 32'(font_addr), 32'h0);
    chk("reset pix_on", 32'(banner_pix_on), 32'h0);
    chk("reset active", 32'(banner_active), 32'h0);
    chk("reset done", 32'(banner_done), 32'h0);
    Reset_n = 1'b1;
    cyc(2);

    // Lose reveal
    didLose = 1'b1; cyc(1); didLose = 1'b0;
    cyc(1);
    chk("lose active", 32'(banner_active), 32'h1);
    framePulses(15);
    chk("lose not done at 15", 32'(banner_done), 32'h0);
    framePulses(1);
    chk("lose done at 16", 32'(banner_done), 32'h1);
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(2);
    chk("cleared active", 32'(banner_active), 32'h0);

    // Both asserted -> LOSE, column 0 glyph rows
    didWin = 1'b1; didLose = 1'b1; cyc(1); didWin = 1'b0; didLose = 1'b0;
    cyc(1);
    DrawX = BX;
    for (int r = 0; r < 16; r++) begin
      DrawY = BY + 10'(r);
      cyc(1);
      chk($sformatf("both addr row%0d", r), 32'(font_addr), 32'h4C0 + 32'(r));
    end
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);

    // Win reveal then pixel sweep across 'W'
    didWin = 1'b1; cyc(1); didWin = 1'b0;
    framePulses(24);
    chk("win done", 32'(banner_done), 32'h1);
    for (int c = 0; c < 8; c++)
      pixAt(BX + 10'(c), BY, $sformatf("W col%0d", c), wRow0[7 - c]);
    pixAt(BX - 10'd1, BY, "left edge", 1'b0);
    pixAt(BX + 10'd56, BY, "right edge", 1'b0);

    // Blink off after BF frames, back on after 2*BF
    framePulses(BF);
    pixAt(BX, BY, "blink off", 1'b0);
    framePulses(BF);
    pixAt(BX, BY, "blink on", 1'b1);

    // Clear coincident with frame_start and didWin
    didWin = 1'b1; clear = 1'b1; frame_start = 1'b1;
    cyc(1);
    clear = 1'b0; frame_start = 1'b0;
    cyc(1);
    chk("clear active low", 32'(banner_active), 32'h0);
    didWin = 1'b0;
    cyc(1);
    chk("rearm active", 32'(banner_active), 32'h1);
    pixAt(BX, BY, "rearm char0", 1'b1);
    pixAt(BX + 10'd8, BY, "rearm char1 hidden", 1'b0);

    // Asynchronous reset mid-REVEAL
    DrawX = BX; DrawY = BY;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async font_addr", 32'(font_addr), 32'h0);
    chk("async pix_on", 32'(banner_pix_on), 32'h0);
    chk("async active", 32'(banner_active), 32'h0);
    chk("async done", 32'(banner_done), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(5);
    chk("post reset active", 32'(banner_active), 32'h0);
    chk("post reset pix", 32'(banner_pix_on), 32'h0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
